// File: rtl/display_pkg.sv
// Shared 640x480@60 display geometry, timing constants, colour type and scan region encoding.
// Constants only; no latency or flow control of its own.
package display_pkg;

  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int FB_ADDR_W = 19;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int CNT_W = 10;

  typedef logic [11:0] rgb_t;

  localparam rgb_t FG_RGB = 12'hFFF;
  localparam rgb_t BG_RGB = 12'h000;

  typedef enum logic [1:0] {R_ACT, R_FP, R_SYNC, R_BP} region_e;

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters and region FSMs producing raw syncs, active and frame markers.
// Zero-latency decode from registered state; everything advances only on pix_en.
module vga_timing_gen
  import display_pkg::*;
#(
  parameter int HACT  = H_ACTIVE,
  parameter int HFP   = H_FP,
  parameter int HSYNC = H_SYNC,
  parameter int HBP   = H_BP,
  parameter int VACT  = V_ACTIVE,
  parameter int VFP   = V_FP,
  parameter int VSYNC = V_SYNC,
  parameter int VBP   = V_BP
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  output logic active,
  output logic hsync_raw,
  output logic vsync_raw,
  output logic frame_end,
  output logic last_active,
  output logic frame_start
);

  localparam int HT = HACT + HFP + HSYNC + HBP;
  localparam int VT = VACT + VFP + VSYNC + VBP;

  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(HACT - 1);
  localparam logic [CNT_W-1:0] H_FP_END   = CNT_W'(HACT + HFP - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(HACT + HFP + HSYNC - 1);
  localparam logic [CNT_W-1:0] H_END      = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(VACT - 1);
  localparam logic [CNT_W-1:0] V_FP_END   = CNT_W'(VACT + VFP - 1);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(VACT + VFP + VSYNC - 1);
  localparam logic [CNT_W-1:0] V_END      = CNT_W'(VT - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_end;
  region_e          h_state, h_next;
  region_e          v_state, v_next;

  assign h_end = (h_cnt == H_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      h_state     <= R_ACT;
      v_state     <= R_ACT;
      frame_start <= 1'b0;
    end else begin
      h_state     <= h_next;
      v_state     <= v_next;
      frame_start <= pix_en && frame_end;
      if (pix_en) begin
        if (h_end) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_END) ? '0 : v_cnt + CNT_W'(1);
        end else begin
          h_cnt <= h_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Region states move on the same pix_en that carries the counter past a boundary.
  always_comb begin
    h_next = h_state;
    if (pix_en) begin
      case (h_state)
        R_ACT:   if (h_cnt == H_ACT_END)  h_next = R_FP;
        R_FP:    if (h_cnt == H_FP_END)   h_next = R_SYNC;
        R_SYNC:  if (h_cnt == H_SYNC_END) h_next = R_BP;
        R_BP:    if (h_end)               h_next = R_ACT;
        default:                          h_next = R_ACT;
      endcase
    end
  end

  always_comb begin
    v_next = v_state;
    if (pix_en && h_end) begin
      case (v_state)
        R_ACT:   if (v_cnt == V_ACT_END)  v_next = R_FP;
        R_FP:    if (v_cnt == V_FP_END)   v_next = R_SYNC;
        R_SYNC:  if (v_cnt == V_SYNC_END) v_next = R_BP;
        R_BP:    if (v_cnt == V_END)      v_next = R_ACT;
        default:                          v_next = R_ACT;
      endcase
    end
  end

  always_comb begin
    active      = (h_state == R_ACT) && (v_state == R_ACT);
    hsync_raw   = (h_state != R_SYNC);
    vsync_raw   = (v_state != R_SYNC);
    frame_end   = h_end && (v_cnt == V_END);
    last_active = active && (h_cnt == H_ACT_END) && (v_cnt == V_ACT_END);
  end

endmodule

// File: rtl/framebuffer_scanout.sv
// Walks the 1-bit framebuffer in raster order and drives VGA colour and syncs from it.
// Pixel data and syncs emerge one pix_en after the address; no backpressure, pix_en gates all state.
module framebuffer_scanout
  import display_pkg::*;
#(
  parameter int HACT  = H_ACTIVE,
  parameter int HFP   = H_FP,
  parameter int HSYNC = H_SYNC,
  parameter int HBP   = H_BP,
  parameter int VACT  = V_ACTIVE,
  parameter int VFP   = V_FP,
  parameter int VSYNC = V_SYNC,
  parameter int VBP   = V_BP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_en,
  output logic [FB_ADDR_W-1:0] read_addr,
  input  logic                 read_data,
  output logic                 hsync,
  output logic                 vsync,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b,
  output logic                 frame_start
);

  logic active;
  logic hsync_raw;
  logic vsync_raw;
  logic frame_end;
  logic last_active;
  rgb_t colour;

  vga_timing_gen #(
    .HACT  (HACT),
    .HFP   (HFP),
    .HSYNC (HSYNC),
    .HBP   (HBP),
    .VACT  (VACT),
    .VFP   (VFP),
    .VSYNC (VSYNC),
    .VBP   (VBP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .active      (active),
    .hsync_raw   (hsync_raw),
    .vsync_raw   (vsync_raw),
    .frame_end   (frame_end),
    .last_active (last_active),
    .frame_start (frame_start)
  );

  // The address parks on the final pixel through vertical blanking so it never leaves the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_addr <= '0;
      colour    <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
    end else if (pix_en) begin
      if (frame_end) begin
        read_addr <= '0;
      end else if (active && !last_active) begin
        read_addr <= read_addr + FB_ADDR_W'(1);
      end
      colour <= active ? (read_data ? FG_RGB : BG_RGB) : '0;
      hsync  <= hsync_raw;
      vsync  <= vsync_raw;
    end
  end

  assign vga_r = colour[11:8];
  assign vga_g = colour[7:4];
  assign vga_b = colour[3:0];

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Drives a full-size and a shrunken-timing scanout side by side against a positional raster model.
module tb_framebuffer_scanout;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
  } cfg_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;

  logic [18:0] ra_b, ra_s;
  logic        rd_b, rd_s;
  logic        hs_b, hs_s, vs_b, vs_s, fs_b, fs_s;
  logic [3:0]  r_b, g_b, b_b, r_s, g_s, b_s;

  cfg_t        big_c, sml_c;
  int          mode;
  bit          rnd [4096];
  int          m;
  bit          edge_p;
  logic [11:0] erb, ers;
  int          tot, bad, hits, max_s;

  always #5 clk = ~clk;

  framebuffer_scanout u_big (
    .clk(clk), .rst(rst), .pix_en(pix_en), .read_addr(ra_b), .read_data(rd_b),
    .hsync(hs_b), .vsync(vs_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .frame_start(fs_b)
  );

  framebuffer_scanout #(
    .HACT(8), .HFP(2), .HSYNC(3), .HBP(2), .VACT(6), .VFP(1), .VSYNC(2), .VBP(2)
  ) u_small (
    .clk(clk), .rst(rst), .pix_en(pix_en), .read_addr(ra_s), .read_data(rd_s),
    .hsync(hs_s), .vsync(vs_s), .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .frame_start(fs_s)
  );

  // Asynchronous-read framebuffer: 0 = diagonal, 1 = all ones, 2 = random contents.
  function automatic logic pix_bit(int md, int a, int w);
    case (md)
      0:       return (a % w) == (a / w);
      1:       return 1'b1;
      default: return rnd[a % 4096];
    endcase
  endfunction

  assign rd_b = pix_bit(mode, int'(ra_b), 640);
  assign rd_s = pix_bit(mode, int'(ra_s), 8);

  function automatic int line_len(cfg_t c);
    return c.ha + c.hf + c.hs + c.hb;
  endfunction

  function automatic int frame_len(cfg_t c);
    return line_len(c) * (c.va + c.vf + c.vs + c.vb);
  endfunction

  // Address of the pixel being fetched after mm pixel ticks since reset.
  function automatic int exp_addr(cfg_t c, int mm);
    int p, x, y, last, a;
    p    = mm % frame_len(c);
    x    = p % line_len(c);
    y    = p / line_len(c);
    last = c.ha * c.va - 1;
    if (y >= c.va) return last;
    a = y * c.ha + ((x < c.ha) ? x : c.ha);
    return (a > last) ? last : a;
  endfunction

  // Output stage shows the position one tick behind the counters.
  function automatic logic exp_hs(cfg_t c, int mm);
    int qx;
    if (mm == 0) return 1'b1;
    qx = ((mm - 1) % frame_len(c)) % line_len(c);
    return !(qx >= c.ha + c.hf && qx < c.ha + c.hf + c.hs);
  endfunction

  function automatic logic exp_vs(cfg_t c, int mm);
    int qy;
    if (mm == 0) return 1'b1;
    qy = ((mm - 1) % frame_len(c)) / line_len(c);
    return !(qy >= c.va + c.vf && qy < c.va + c.vf + c.vs);
  endfunction

  function automatic logic [11:0] exp_rgb(cfg_t c, int mm);
    int q, qx, qy;
    q  = (mm - 1) % frame_len(c);
    qx = q % line_len(c);
    qy = q / line_len(c);
    if (qx < c.ha && qy < c.va)
      return pix_bit(mode, qy * c.ha + qx, c.ha) ? 12'hFFF : 12'h000;
    return 12'h000;
  endfunction

  task automatic chk(input string tag, input logic [18:0] act, input logic [18:0] exp);
    tot++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s m=%0d observed=%0h expected=%0h", tag, m, act, exp);
    end
  endtask

  task automatic check_all();
    chk("big_addr",   ra_b, 19'(exp_addr(big_c, m)));
    chk("big_hsync",  19'(hs_b), 19'(exp_hs(big_c, m)));
    chk("big_vsync",  19'(vs_b), 19'(exp_vs(big_c, m)));
    chk("big_rgb",    19'({r_b, g_b, b_b}), 19'(erb));
    chk("big_fstart", 19'(fs_b), 19'(edge_p && m > 0 && (m % frame_len(big_c)) == 0));
    chk("sml_addr",   ra_s, 19'(exp_addr(sml_c, m)));
    chk("sml_hsync",  19'(hs_s), 19'(exp_hs(sml_c, m)));
    chk("sml_vsync",  19'(vs_s), 19'(exp_vs(sml_c, m)));
    chk("sml_rgb",    19'({r_s, g_s, b_s}), 19'(ers));
    chk("sml_fstart", 19'(fs_s), 19'(edge_p && m > 0 && (m % frame_len(sml_c)) == 0));
  endtask

  // One clock: apply inputs, let the edge pass, advance the model, compare.
  task automatic step(input bit pe, input bit r);
    rst    = r;
    pix_en = pe;
    @(posedge clk);
    #1;
    if (r) begin
      m = 0; edge_p = 1'b0; erb = '0; ers = '0;
    end else if (pe) begin
      m++;
      edge_p = 1'b1;
      erb = exp_rgb(big_c, m);
      ers = exp_rgb(sml_c, m);
      if (mode == 0 && m <= frame_len(sml_c) && {r_s, g_s, b_s} === 12'hFFF) hits++;
    end else begin
      edge_p = 1'b0;
    end
    if (int'(ra_s) > max_s) max_s = int'(ra_s);
    check_all();
  endtask

  // sp: 0 = pix_en held low, <0 = random ticks, n = one tick every n clocks.
  task automatic run(input int n, input int sp);
    bit pe;
    for (int i = 0; i < n; i++) begin
      if (sp == 0)     pe = 1'b0;
      else if (sp < 0) pe = ($urandom_range(0, 2) == 0);
      else             pe = ((i % sp) == sp - 1);
      step(pe, 1'b0);
    end
  endtask

  initial begin
    big_c = '{640, 16, 96, 48, 480, 10, 2, 33};
    sml_c = '{8, 2, 3, 2, 6, 1, 2, 2};
    for (int i = 0; i < 4096; i++) rnd[i] = 1'($urandom_range(0, 1));
    tot = 0; bad = 0; hits = 0; max_s = 0; m = 0; edge_p = 1'b0;
    erb = '0; ers = '0;
    mode = 0;
    rst = 1'b1;
    pix_en = 1'b0;

    step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    // Diagonal pattern, tick every 4th clock: small instance covers two-plus frames.
    run(1600, 4);
    chk("sml_diag_hits", 19'(hits), 19'((sml_c.ha < sml_c.va) ? sml_c.ha : sml_c.va));
    chk("sml_addr_max",  19'(max_s), 19'(sml_c.ha * sml_c.va - 1));

    // All ones: any lit pixel in blanking is an error; full-rate ticks cross line 0 -> 1.
    mode = 1;
    run(1800, 1);

    mode = 2;
    run(1500, -1);

    // Freeze mid-line, then resume at half rate.
    run(50, 0);
    run(400, 2);

    // Synchronous reset mid-frame, then a full small frame to the first frame_start.
    step(1'b1, 1'b1);
    run(800, 4);
    run(600, 1);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
